// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM state encoding, register offsets and STATUS bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam logic [3:0] ADDR_TXDATA = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;

   localparam int STATUS_FULL_BIT     = 0;
   localparam int STATUS_EMPTY_BIT    = 1;
   localparam int STATUS_SHIFTING_BIT = 2;
   localparam int STATUS_OVERFLOW_BIT = 3;
   localparam int STATUS_COUNT_LSB    = 8;

   // Occupancy counter width: must hold 0..depth inclusive.
   function automatic int fifo_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO. A push while full is accepted only when a pop
// happens in the same cycle; otherwise it is silently dropped.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == {CNT_W{1'b0}});
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   // Next-state for storage, pointers (natural wrap) and occupancy count
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue a byte; the
// serialiser drains the queue back-to-back with no idle gap between frames.
module uart_tx_periph
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 868,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_select,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  mask,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        tx_busy,
   output logic        irq
);

   localparam int CNT_W  = fifo_cnt_width(FIFO_DEPTH);
   localparam int BAUD_W = $clog2(CLK_PER_BIT);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q, ovf_d;
   logic              irq_q, irq_d;

   logic              wr_txdata;
   logic              wr_status;
   logic              rd_status;
   logic              pop;
   logic              push_ok;
   logic              tick;
   logic [7:0]        fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  count_next;
   logic [31:0]       status_word;

   assign wr_txdata = uart_select & wr_en & (addr == ADDR_TXDATA) & mask[0];
   assign wr_status = uart_select & wr_en & (addr == ADDR_STATUS) & mask[0];
   assign rd_status = uart_select & rd_en & (addr == ADDR_STATUS);
   assign tick      = (baud_q == BAUD_W'(CLK_PER_BIT - 1));
   assign push_ok   = wr_txdata & (~fifo_full | pop);
   assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (pop),
      .wdata (wdata[7:0]),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Serialiser FSM: start bit, 8 data bits LSB first, stop bit
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = {BAUD_W{1'b0}};
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_head;
               tx_d    = 1'b0;
               state_d = START;
            end else begin
               tx_d    = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               baud_d  = {BAUD_W{1'b0}};
               tx_d    = shift_q[0];
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (tick) begin
               baud_d = {BAUD_W{1'b0}};
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (tick) begin
               baud_d = {BAUD_W{1'b0}};
               // Chain straight into the next frame when more data is queued
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_head;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = {BAUD_W{1'b0}};
            tx_d    = 1'b1;
         end
      endcase
   end

   // Sticky overflow flag and registered interrupt level
   always_comb begin
      ovf_d = ovf_q;
      if (wr_status && wdata[STATUS_OVERFLOW_BIT]) begin
         ovf_d = 1'b0;
      end else if (wr_txdata && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      irq_d = (count_next == {CNT_W{1'b0}}) && (state_d == IDLE);
   end

   // STATUS assembly and load data mux
   always_comb begin
      status_word                                 = 32'd0;
      status_word[STATUS_FULL_BIT]                = fifo_full;
      status_word[STATUS_EMPTY_BIT]               = fifo_empty;
      status_word[STATUS_SHIFTING_BIT]            = (state_q != IDLE);
      status_word[STATUS_OVERFLOW_BIT]            = ovf_q;
      status_word[STATUS_COUNT_LSB +: CNT_W]      = fifo_count;
      if (rd_status) begin
         rdata = status_word;
      end else begin
         rdata = 32'd0;
      end
   end

   // Serialiser and flag registers; reset forces the line idle at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= {BAUD_W{1'b0}};
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         irq_q   <= irq_d;
      end
   end

   assign tx      = tx_q;
   assign irq     = irq_q;
   assign tx_busy = fifo_full;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with CLK_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_periph;

   logic        clk = 1'b0;
   logic        reset;
   logic        uart_select;
   logic        wr_en;
   logic        rd_en;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  mask;
   logic [31:0] rdata;
   logic        tx;
   logic        tx_busy;
   logic        irq;

   int checks = 0;
   int errors = 0;

   uart_tx_periph #(
      .CLK_PER_BIT (4),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .uart_select (uart_select),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .addr        (addr),
      .wdata       (wdata),
      .mask        (mask),
      .rdata       (rdata),
      .tx          (tx),
      .tx_busy     (tx_busy),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Store: inputs set just after an edge, captured at the next edge
   task automatic bus_store(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
      uart_select = 1'b1;
      wr_en       = 1'b1;
      addr        = a;
      wdata       = d;
      mask        = m;
      @(posedge clk);
      #1;
      uart_select = 1'b0;
      wr_en       = 1'b0;
      mask        = 4'b0000;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      uart_select = 1'b1;
      rd_en       = 1'b1;
      addr        = a;
      #1;
      d           = rdata;
      uart_select = 1'b0;
      rd_en       = 1'b0;
      addr        = 4'h0;
   endtask

   // Check tx every cycle across nframes frames, starting at the current cycle
   task automatic expect_frames(input logic [7:0] b0, input logic [7:0] b1, input int nframes);
      logic [9:0] fr;
      logic       exp_bit;
      for (int k = 0; k < nframes * 40; k++) begin
         if (k != 0) begin
            @(posedge clk);
            #1;
         end
         fr      = {1'b1, ((k / 40) == 0) ? b0 : b1, 1'b0};
         exp_bit = fr[(k % 40) / 4];
         chk($sformatf("tx_k%0d", k), {31'd0, tx}, {31'd0, exp_bit});
         if (k == 20) begin
            chk("irq_mid_frame", {31'd0, irq}, 32'd0);
         end
      end
   endtask

   logic [31:0] rd;
   int          w;
   int          zeros;

   initial begin
      reset       = 1'b0;
      uart_select = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      addr        = 4'h0;
      wdata       = 32'd0;
      mask        = 4'b0000;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_irq", {31'd0, irq}, 32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("idle_tx", {31'd0, tx}, 32'd1);
      chk("idle_irq", {31'd0, irq}, 32'd1);
      chk("idle_busy", {31'd0, tx_busy}, 32'd0);
      bus_read(4'h4, rd);
      chk("idle_status", rd, 32'h0000_0002);
      bus_read(4'h0, rd);
      chk("txdata_read", rd, 32'd0);
      uart_select = 1'b1;
      addr        = 4'h4;
      #1;
      chk("no_rd_en_rdata", rdata, 32'd0);
      uart_select = 1'b0;
      addr        = 4'h0;

      // Single frame 0xA5
      @(posedge clk);
      #1;
      bus_store(4'h0, 32'hFFFF_FFA5, 4'b0001);
      chk("push_edge_tx", {31'd0, tx}, 32'd1);
      @(posedge clk);
      #1;
      expect_frames(8'hA5, 8'h00, 1);
      @(posedge clk);
      #1;
      chk("a5_end_tx", {31'd0, tx}, 32'd1);
      chk("a5_end_irq", {31'd0, irq}, 32'd1);

      // Back-to-back frames with no gap
      repeat (3) @(posedge clk);
      #1;
      bus_store(4'h0, 32'h0000_0055, 4'b0001);
      bus_store(4'h0, 32'h0000_000F, 4'b0001);
      expect_frames(8'h55, 8'h0F, 2);
      @(posedge clk);
      #1;
      chk("b2b_end_tx", {31'd0, tx}, 32'd1);
      chk("b2b_end_irq", {31'd0, irq}, 32'd1);

      // Fill the FIFO while shifting, honouring tx_busy
      repeat (2) @(posedge clk);
      #1;
      bus_store(4'h0, 32'h0000_0010, 4'b0001);
      for (int i = 1; i < 10; i++) begin
         w = 0;
         while (tx_busy && w < 200) begin
            @(posedge clk);
            #1;
            w++;
         end
         chk("busy_wait", {31'd0, tx_busy}, 32'd0);
         bus_store(4'h0, 32'h0000_0010 + i, 4'b0001);
         if (i == 8) begin
            chk("full_busy", {31'd0, tx_busy}, 32'd1);
            bus_read(4'h4, rd);
            chk("full_status", rd, 32'h0000_0805);
         end
      end
      bus_read(4'h4, rd);
      chk("stall_no_ovf", rd, 32'h0000_0805);
      bus_store(4'h0, 32'h0000_00EE, 4'b0001);
      bus_read(4'h4, rd);
      chk("ovf_set", rd, 32'h0000_080D);
      bus_store(4'h4, 32'h0000_0008, 4'b0001);
      bus_read(4'h4, rd);
      chk("ovf_clear", rd, 32'h0000_0805);
      bus_store(4'h0, 32'h0000_0077, 4'b0010);
      bus_read(4'h4, rd);
      chk("mask_no_push", rd, 32'h0000_0805);
      bus_store(4'h8, 32'h0000_0099, 4'b0001);
      bus_read(4'h4, rd);
      chk("unmapped_wr", rd, 32'h0000_0805);
      bus_read(4'h8, rd);
      chk("unmapped_rd", rd, 32'd0);

      // Drain
      w = 0;
      while (!irq && w < 1000) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain_irq", {31'd0, irq}, 32'd1);
      bus_read(4'h4, rd);
      chk("drain_status", rd, 32'h0000_0002);

      // Reset mid-DATA
      @(posedge clk);
      #1;
      bus_store(4'h0, 32'h0000_003C, 4'b0001);
      @(posedge clk);
      #1;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_reset_tx", {31'd0, tx}, 32'd0);
      reset = 1'b0;
      #1;
      chk("async_reset_tx", {31'd0, tx}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus_read(4'h4, rd);
      chk("post_reset_status", rd, 32'h0000_0002);
      zeros = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (tx == 1'b0) begin
            zeros++;
         end
      end
      chk("post_reset_quiet", zeros, 32'd0);
      chk("post_reset_irq", {31'd0, irq}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter slave on the load/store unit's data bus, directly downstream of the LSU's uart_select/addr/data/mask outputs.
- Accepts bytes from core store instructions into a small FIFO and serialises them 8N1, LSB first, on a single tx pin.
- Drives tx_busy back to the LSU so stores stall while the FIFO is full.

Parameters:
- CLK_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- uart_select  in  1  chip select from LSU; bus access valid only when high
- wr_en  in  1  store strobe (qualified by uart_select)
- rd_en  in  1  load strobe (qualified by uart_select)
- addr  in  4  byte offset within peripheral: 0x0 TXDATA, 0x4 STATUS
- wdata  in  32  store data
- mask  in  4  byte-lane enables from LSU
- rdata  out  32  load data, combinational from current state
- tx  out  1  serial line, registered, idle high
- tx_busy  out  1  high when FIFO full; LSU must hold the store
- irq  out  1  level interrupt, high when FIFO empty and shifter idle

Behaviour:
- Reset (reset=0, async): tx=1, tx_busy=0, irq=1, rdata=0.
  - FIFO empty, pointers=0, overflow=0.
  - FSM=IDLE, bit/baud counters=0.
- Push condition: uart_select & wr_en & addr==0x0 & mask[0]. Pushes wdata[7:0]; other lanes ignored.
- Push when full with no same-cycle pop: byte dropped, sticky overflow set.
- Push when full with same-cycle pop: accepted; count unchanged.
- Store to 0x4 with mask[0] & wdata[3]=1 clears overflow. All other STATUS bits are read-only.
- STATUS read value:
  - bit0 full
  - bit1 empty
  - bit2 shifting (FSM != IDLE)
  - bit3 overflow
  - bits[7+W:8] count, where W=log2(FIFO_DEPTH)+1
  - rest 0
- rdata: TXDATA read returns 0. rdata is 0 whenever uart_select & rd_en is low.
- tx_busy = full, combinational from count.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLK_PER_BIT-1; "tick" = counter at CLK_PER_BIT-1.
  - IDLE: if FIFO non-empty → pop head into shift register, tx<=0, baud<=0, go START.
  - START: on tick → tx<=shift[0], bit<=0, go DATA.
  - DATA: on tick → if bit==7, tx<=1, go STOP; else shift right, tx<=next bit, bit++.
  - STOP: on tick → if FIFO non-empty, pop and go START with tx<=0 (no idle gap); else go IDLE.
- Latency: push at edge N into an empty FIFO with FSM in IDLE → pop and tx=0 at edge N+1.
- Frame timing: each bit lasts exactly CLK_PER_BIT cycles; a frame is 10*CLK_PER_BIT cycles.
- Simultaneous push into empty FIFO with IDLE: the byte is written at edge N and popped at N+1; no bypass.
- irq = empty & (FSM==IDLE), registered.
- Pointers wrap modulo FIFO_DEPTH. Count is a separate W-bit counter, 0..FIFO_DEPTH.
- Reset mid-frame: tx immediately 1, partial byte and FIFO contents discarded.
- Unmapped addresses: writes ignored, reads return 0.

Decomposition:
- Shared package uart_pkg:
  - typedef enum for the FSM states {IDLE, START, DATA, STOP}
  - localparams ADDR_TXDATA=4'h0 and ADDR_STATUS=4'h4
  - STATUS bit-index constants
- One sub-module, uart_tx_fifo: parameterised sync FIFO with push/pop/full/empty/count, same clk and async active-low reset.

Test Plan:
- Reset, then idle 20 cycles → tx=1, irq=1, tx_busy=0, STATUS read=0x0000_0002.
- CLK_PER_BIT=4, store 0xA5 to 0x0 at edge N → tx=0 from N+1 for 4 cycles; data bits 1,0,1,0,0,1,0,1 each 4 cycles; stop=1; irq rises after 40 cycles.
- Store 0x55 then 0x0F back-to-back → second start bit begins on the cycle right after the first stop bit ends (frames 80 cycles total, no gap).
- FIFO_DEPTH=8, 10 consecutive stores while shifting → tx_busy high after the FIFO fills.
  - Stores proceed while tx_busy=0; with a stalled LSU, no overflow.
  - Forced push while full → STATUS bit3=1; store 0x8 to 0x4 → bit3=0.
- Store with mask=4'b0010 to 0x0 → no push, STATUS count unchanged.
- Assert reset mid-DATA for 1 cycle → tx=1 asynchronously, STATUS=0x2 after release, no further serial activity.
